pattern_gen_multi: RTL and testbench
====================================

# pattern_gen_multi

Parametrised, registered test-pattern generator for the VGA pixel path. Replaces the fixed eight-bar column decoder with four selectable patterns: vertical bars, horizontal bars, checkerboard and frame-cycled solid colour. An optional per-frame horizontal scroll is included. Sits between the VGA timing generator (which supplies column, row, video_on and frame_start) and the RGB output pins.

## Interface
- H_ACTIVE, 640, visible columns; column values 0..H_ACTIVE-1 are active.
- V_ACTIVE, 480, visible rows.
- POS_W, 10, width of column/row.
- COLOR_W, 3, rgb width (one bit per channel at default).
- BAR_COUNT, 8, bars per screen in bar modes; 1..2^COLOR_W.
- CHECK_SHIFT, 5, checker cell size is 2^CHECK_SHIFT pixels.
- SCROLL_STEP, 1, columns advanced per frame; must be less than H_ACTIVE.
- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active low
- column  in  POS_W  current pixel column
- row  in  POS_W  current pixel row
- video_on  in  1  high while (column,row) is in the visible area
- frame_start  in  1  one-cycle pulse once per frame, during blanking
- mode_sel  in  2  requested pattern; sampled only on frame_start
- rgb  out  COLOR_W  registered pixel colour
- cur_mode  out  2  pattern currently in effect

## Operation
- Mode register: loads mode_sel on frame_start; otherwise holds. Modes are never changed mid-frame.
- Frame counter (8 bit): increments on frame_start and wraps 255->0.
- Scroll offset (POS_W): on frame_start, next = offset+SCROLL_STEP. If the sum is >= H_ACTIVE, subtract H_ACTIVE.
- Effective column: col_eff = column+offset. If the sum is >= H_ACTIVE, subtract H_ACTIVE. Compute at POS_W+1 bits to avoid overflow.
- Bar widths: BAR_W = H_ACTIVE/BAR_COUNT and BAR_H = V_ACTIVE/BAR_COUNT (integer).
- Bar index: the largest k in 0..BAR_COUNT-1 with k*BAR_W <= pos. Positions beyond the last boundary saturate at BAR_COUNT-1.
- Mode 0 (vertical bars): colour = bar index of col_eff. At defaults: 0..79 -> 000, 80..159 -> 001, …, 560..639 -> 111.
- Mode 1 (horizontal bars): colour = bar index of row, using BAR_H.
- Mode 2 (checker): colour is all ones when col_eff[CHECK_SHIFT] XOR row[CHECK_SHIFT] is set; otherwise zero.
- Mode 3 (solid): colour = frame_cnt[COLOR_W+5:6], so the colour advances every 64 frames.
- Blanking: when video_on is low, the next rgb is 0 regardless of mode.

## Timing
- Latency: rgb reflects the column/row/video_on presented one clock earlier (single output register).
- Values after reset (rst_n low at a clock edge): rgb=0, cur_mode=0, offset=0, frame_cnt=0.
- Reset mid-frame: output is forced to 0 on the next edge. The mode-0 pattern with zero offset resumes on the first cycle after rst_n rises.
- frame_start update: mode, offset and frame_cnt update at the frame_start edge. The pixel sampled in the frame_start cycle uses the old values. cur_mode changes one cycle after frame_start.
- Continuous frame_start (every cycle) is legal: the offset advances every cycle.
- frame_start and rst_n low in the same cycle: reset wins.

## Configuration
- PATTERN_SCROLL_EN defined: the offset register and wrap logic exist, and modes 0 and 2 scroll left by SCROLL_STEP columns per frame.
- PATTERN_SCROLL_EN undefined: the offset is the constant 0, col_eff = column, and no scroll logic is synthesised. All other behaviour is identical.

## Structure
- Package pattern_pkg holds:
  - mode constants MODE_VBAR=0, MODE_HBAR=1, MODE_CHECK=2, MODE_SOLID=3;
  - a 2-bit pattern_mode_t typedef;
  - the frame counter width constant (8).
- Sub-module pattern_bar_index: parameters POS_W, BAR_W, BAR_COUNT, COLOR_W.
  - Combinational comparator chain mapping pos to the saturated bar index.
  - Instantiated twice: once for col_eff with BAR_W, once for row with BAR_H.

## Test plan
- Reset, mode_sel=0, no frame_start, video_on=1, sweep column 0..639 -> rgb one cycle later steps 000 at 0, 001 at 80, …, 111 at 560; values 79->000 and 80->001 at the boundary.
- frame_start with mode_sel=1, then row 0, 59, 60, 479 -> rgb 000, 000, 001, 111. cur_mode is 1 from the cycle after frame_start.
- Mode 2 at column 31/row 0 -> 000; column 32/row 0 -> 111; column 32/row 32 -> 000. Hold video_on=0 at column 32/row 0 -> rgb 000.
- With PATTERN_SCROLL_EN and SCROLL_STEP=1: 640 frame_start pulses in mode 0 -> offset wraps to 0. After 1 pulse, column 79 -> 001. After 639 pulses, column 1 -> 000.
- Mode 3: 64 frame_start pulses -> rgb 001. 512 pulses -> rgb 000 (frame_cnt wrap).
- Assert rst_n low mid-line in mode 2 with offset 5 -> next rgb=0, cur_mode=0, offset=0. Column 80 after release -> 001.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the multi-pattern VGA test-pattern generator:
// pattern mode encoding and the frame counter width.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_VBAR  = 2'd0,
        MODE_HBAR  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } pattern_mode_t;

    localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/pattern_bar_index.sv
// Maps a pixel position to its bar number using a chain of constant
// boundary comparators; positions past the last boundary saturate.
module pattern_bar_index #(
    parameter int POS_W     = 10,
    parameter int BAR_W     = 80,
    parameter int BAR_COUNT = 8,
    parameter int COLOR_W   = 3
) (
    input  logic [POS_W-1:0]   pos,
    output logic [COLOR_W-1:0] index
);

    logic [BAR_COUNT-1:0] at_or_past;

    generate
        for (genvar gi = 0; gi < BAR_COUNT; gi++) begin : g_bound
            if (gi == 0) begin : g_first
                assign at_or_past[gi] = 1'b1;
            end else begin : g_rest
                localparam logic [POS_W+1:0] BOUND = (POS_W+2)'(gi * BAR_W);
                assign at_or_past[gi] = ({2'b00, pos} >= BOUND);
            end
        end
    endgenerate

    // Boundaries are monotonic, so the highest set flag is the bar index.
    always_comb begin
        index = '0;
        for (int k = 0; k < BAR_COUNT; k++) begin
            if (at_or_past[k]) begin
                index = COLOR_W'(k);
            end
        end
    end

endmodule

// File: rtl/pattern_gen_multi.sv
// Registered VGA test-pattern generator: vertical/horizontal bars, checker
// and frame-cycled solid colour. Define PATTERN_SCROLL_EN for per-frame scroll.
module pattern_gen_multi
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int POS_W       = 10,
    parameter int COLOR_W     = 3,
    parameter int BAR_COUNT   = 8,
    parameter int CHECK_SHIFT = 5,
    parameter int SCROLL_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [POS_W-1:0]   column,
    input  logic [POS_W-1:0]   row,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic [1:0]         mode_sel,
    output logic [COLOR_W-1:0] rgb,
    output logic [1:0]         cur_mode
);

    localparam int BAR_W = H_ACTIVE / BAR_COUNT;
    localparam int BAR_H = V_ACTIVE / BAR_COUNT;
    localparam logic [POS_W:0] H_LIM = (POS_W+1)'(H_ACTIVE);

    pattern_mode_t            mode_reg;
    logic [FRAME_CNT_W-1:0]   frame_cnt_reg;
    logic [COLOR_W-1:0]       rgb_reg;
    logic [COLOR_W-1:0]       rgb_next;
    logic [POS_W-1:0]         col_eff;
    logic [COLOR_W-1:0]       vbar_index;
    logic [COLOR_W-1:0]       hbar_index;
    logic [COLOR_W+5:0]       frame_ext;

`ifdef PATTERN_SCROLL_EN
    localparam logic [POS_W:0] STEP = (POS_W+1)'(SCROLL_STEP);

    logic [POS_W-1:0] offset_reg;
    logic [POS_W:0]   offset_sum;
    logic [POS_W:0]   col_sum;

    assign offset_sum = {1'b0, offset_reg} + STEP;
    assign col_sum    = {1'b0, column} + {1'b0, offset_reg};
    // Both sums stay below 2*H_ACTIVE, so one conditional subtract wraps them.
    assign col_eff    = POS_W'((col_sum >= H_LIM) ? (col_sum - H_LIM) : col_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_reg <= '0;
        end else if (frame_start) begin
            offset_reg <= POS_W'((offset_sum >= H_LIM) ? (offset_sum - H_LIM) : offset_sum);
        end
    end
`else
    assign col_eff = column;
`endif

    pattern_bar_index #(
        .POS_W     (POS_W),
        .BAR_W     (BAR_W),
        .BAR_COUNT (BAR_COUNT),
        .COLOR_W   (COLOR_W)
    ) u_vbar (
        .pos   (col_eff),
        .index (vbar_index)
    );

    pattern_bar_index #(
        .POS_W     (POS_W),
        .BAR_W     (BAR_H),
        .BAR_COUNT (BAR_COUNT),
        .COLOR_W   (COLOR_W)
    ) u_hbar (
        .pos   (row),
        .index (hbar_index)
    );

    // Solid colour takes counter bits [COLOR_W+5:6]; bits above the counter read as 0.
    assign frame_ext = (COLOR_W+6)'(frame_cnt_reg);

    always_comb begin
        rgb_next = '0;
        if (video_on) begin
            case (mode_reg)
                MODE_VBAR:  rgb_next = vbar_index;
                MODE_HBAR:  rgb_next = hbar_index;
                MODE_CHECK: rgb_next = {COLOR_W{col_eff[CHECK_SHIFT] ^ row[CHECK_SHIFT]}};
                MODE_SOLID: rgb_next = COLOR_W'(frame_ext >> 6);
                default:    rgb_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_reg       <= '0;
            mode_reg      <= MODE_VBAR;
            frame_cnt_reg <= '0;
        end else begin
            rgb_reg <= rgb_next;
            if (frame_start) begin
                mode_reg      <= pattern_mode_t'(mode_sel);
                frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
            end
        end
    end

    assign rgb      = rgb_reg;
    assign cur_mode = mode_reg;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Self-checking bench for pattern_gen_multi: directed scenarios plus random
// pixels against an arithmetic reference model (scroll follows PATTERN_SCROLL_EN).
module tb_pattern_gen_multi;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BAR_COUNT = 8;
    localparam int STEP      = 1;

`ifdef PATTERN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] column;
    logic [9:0] row;
    logic       video_on;
    logic       frame_start;
    logic [1:0] mode_sel;
    logic [2:0] rgb;
    logic [1:0] cur_mode;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int m_mode = 0;
    int m_off  = 0;
    int m_fcnt = 0;

    always #5 clk = ~clk;

    pattern_gen_multi dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .column      (column),
        .row         (row),
        .video_on    (video_on),
        .frame_start (frame_start),
        .mode_sel    (mode_sel),
        .rgb         (rgb),
        .cur_mode    (cur_mode)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int bar_of(input int pos, input int width);
        int b;
        b = pos / width;
        return (b > BAR_COUNT - 1) ? BAR_COUNT - 1 : b;
    endfunction

    function automatic int exp_pixel(input int c, input int r, input bit v);
        int ce;
        if (!v) return 0;
        ce = SCROLL ? (c + m_off) % H_ACTIVE : c;
        case (m_mode)
            0: return bar_of(ce, H_ACTIVE / BAR_COUNT);
            1: return bar_of(r, V_ACTIVE / BAR_COUNT);
            2: return ((((ce / 32) + (r / 32)) % 2) == 1) ? 7 : 0;
            default: return (m_fcnt / 64) % 8;
        endcase
    endfunction

    // One pixel clock: drive, predict, clock, update model, compare.
    task automatic step(input int c, input int r, input bit v, input bit fs,
                        input int ms, input bit rn, input string tag, input bit log);
        int exp_rgb;
        logic [9:0] cv;
        logic [9:0] rv;
        cv = 10'(c);
        rv = 10'(r);
        column      = cv;
        row         = rv;
        video_on    = v;
        frame_start = fs;
        mode_sel    = 2'(ms);
        rst_n       = rn;
        exp_rgb = rn ? exp_pixel(c, r, v) : 0;
        @(posedge clk);
        if (!rn) begin
            m_mode = 0;
            m_off  = 0;
            m_fcnt = 0;
        end else if (fs) begin
            m_mode = ms;
            m_off  = (m_off + STEP) % H_ACTIVE;
            m_fcnt = (m_fcnt + 1) % 256;
        end
        #1;
        check_eq({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        check_eq({tag, "_mode"}, 32'(cur_mode), 32'(m_mode));
        if (log)
            $display("tx %s col=%0d row=%0d von=%0d fs=%0d rst_n=%0d -> rgb=%0d cur_mode=%0d",
                     tag, c, r, v, fs, rn, rgb, cur_mode);
    endtask

    task automatic do_reset();
        step(0, 0, 1'b1, 1'b1, 3, 1'b0, "reset", 1'b1);
        step(0, 0, 1'b0, 1'b0, 0, 1'b0, "reset", 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; column = '0; row = '0; video_on = 1'b0;
        frame_start = 1'b0; mode_sel = '0;
        #1;
        do_reset();
        check_eq("reset_rgb_zero", 32'(rgb), 32'd0);
        check_eq("reset_mode_zero", 32'(cur_mode), 32'd0);

        // Mode 0 sweep with zero offset, plus explicit bar-boundary values
        for (int c = 0; c < H_ACTIVE; c++)
            step(c, 0, 1'b1, 1'b0, 0, 1'b1, "vbar_sweep", 1'b0);
        step(79, 0, 1'b1, 1'b0, 0, 1'b1, "vbar_79", 1'b1);
        check_eq("vbar_79_const", 32'(rgb), 32'd0);
        step(80, 0, 1'b1, 1'b0, 0, 1'b1, "vbar_80", 1'b1);
        check_eq("vbar_80_const", 32'(rgb), 32'd1);
        step(639, 0, 1'b1, 1'b0, 0, 1'b1, "vbar_639", 1'b1);
        check_eq("vbar_639_const", 32'(rgb), 32'd7);

        // Mode 1 via frame_start; pixel in the frame_start cycle still uses mode 0
        step(0, 0, 1'b0, 1'b1, 1, 1'b1, "fs_hbar", 1'b1);
        check_eq("hbar_cur_mode", 32'(cur_mode), 32'd1);
        step(0, 0, 1'b1, 1'b0, 1, 1'b1, "hbar_r0", 1'b1);
        step(0, 59, 1'b1, 1'b0, 1, 1'b1, "hbar_r59", 1'b1);
        step(0, 60, 1'b1, 1'b0, 1, 1'b1, "hbar_r60", 1'b1);
        check_eq("hbar_60_const", 32'(rgb), 32'd1);
        step(0, 479, 1'b1, 1'b0, 1, 1'b1, "hbar_r479", 1'b1);
        check_eq("hbar_479_const", 32'(rgb), 32'd7);

        // Mode 2 checker boundaries and blanking
        step(0, 0, 1'b0, 1'b1, 2, 1'b1, "fs_check", 1'b1);
        step(31, 0, 1'b1, 1'b0, 2, 1'b1, "chk_31_0", 1'b1);
        step(32, 0, 1'b1, 1'b0, 2, 1'b1, "chk_32_0", 1'b1);
        step(32, 32, 1'b1, 1'b0, 2, 1'b1, "chk_32_32", 1'b1);
        step(32, 0, 1'b0, 1'b0, 2, 1'b1, "chk_blank", 1'b1);
        check_eq("chk_blank_const", 32'(rgb), 32'd0);

        // Random pixels with occasional mode changes
        for (int i = 0; i < 2000; i++)
            step($urandom_range(H_ACTIVE - 1), $urandom_range(V_ACTIVE - 1),
                 ($urandom_range(7) != 0), ($urandom_range(49) == 0),
                 $urandom_range(3), 1'b1, "rand", 1'b0);

        // Continuous frame_start: full offset wrap in mode 0
        do_reset();
        step(0, 0, 1'b0, 1'b1, 0, 1'b1, "scroll_first", 1'b1);
        step(79, 0, 1'b1, 1'b0, 0, 1'b1, "scroll_1_c79", 1'b1);
        for (int i = 1; i < 639; i++)
            step($urandom_range(H_ACTIVE - 1), 0, 1'b1, 1'b1, 0, 1'b1, "scroll_run", 1'b0);
        step(1, 0, 1'b1, 1'b0, 0, 1'b1, "scroll_639_c1", 1'b1);
        step(0, 0, 1'b0, 1'b1, 0, 1'b1, "scroll_640", 1'b1);
        for (int c = 0; c < H_ACTIVE; c += 40)
            step(c, 0, 1'b1, 1'b0, 0, 1'b1, "scroll_wrapped", 1'b0);
        step(80, 0, 1'b1, 1'b0, 0, 1'b1, "scroll_wrap_c80", 1'b1);
        check_eq("scroll_wrap_const", 32'(rgb), 32'd1);

        // Mode 3 solid colour over 512 frames
        do_reset();
        for (int i = 0; i < 512; i++) begin
            step(5, 5, 1'b1, 1'b1, 3, 1'b1, "solid_run", 1'b0);
            if (i == 63) begin
                step(5, 5, 1'b1, 1'b0, 3, 1'b1, "solid_64", 1'b1);
                check_eq("solid_64_const", 32'(rgb), 32'd1);
            end
        end
        step(5, 5, 1'b1, 1'b0, 3, 1'b1, "solid_512", 1'b1);
        check_eq("solid_512_const", 32'(rgb), 32'd0);

        // Mid-line reset in mode 2 with offset 5, reset beating frame_start
        do_reset();
        for (int i = 0; i < 5; i++)
            step(0, 0, 1'b0, 1'b1, 2, 1'b1, "mid_fs", 1'b0);
        for (int c = 100; c < 106; c++)
            step(c, 3, 1'b1, 1'b0, 2, 1'b1, "mid_line", 1'b0);
        step(106, 3, 1'b1, 1'b1, 3, 1'b0, "mid_reset", 1'b1);
        check_eq("mid_reset_rgb", 32'(rgb), 32'd0);
        check_eq("mid_reset_mode", 32'(cur_mode), 32'd0);
        step(80, 3, 1'b1, 1'b0, 2, 1'b1, "mid_release_c80", 1'b1);
        check_eq("mid_release_const", 32'(rgb), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
